fifth_boot_loader: RTL and testbench

//  Boot sequencer for the fifth CPU. Holds the core in reset (cpu_reset low) while a

---
 rtl/fifth_boot_loader_if.sv | 26 ++
 rtl/fifth_boot_loader.sv | 172 +++++++++++++++++
 tb/tb_fifth_boot_loader.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifth_boot_loader_if.sv
// Byte-stream, control and code-RAM write signals of the fifth boot loader.
// master = host/system side, slave = loader.
interface fifth_boot_loader_if #(
  parameter int unsigned ADDR_WIDTH = 13
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  load_req;
  logic                  code_wr_en;
  logic [ADDR_WIDTH-1:0] code_wr_addr;
  logic [15:0]           code_wr_data;
  logic                  cpu_reset;
  logic                  done;
  logic                  error;

  modport master (
    output rx_data, rx_valid, load_req,
    input  rx_ready, code_wr_en, code_wr_addr, code_wr_data, cpu_reset, done, error
  );

  modport slave (
    input  rx_data, rx_valid, load_req,
    output rx_ready, code_wr_en, code_wr_addr, code_wr_data, cpu_reset, done, error
  );
endinterface

// File: rtl/fifth_boot_loader.sv
// Boot sequencer: holds the fifth core in reset while a framed image
// (MAGIC, LEN lo/hi, LEN words, XOR checksum) is written into code RAM.
module fifth_boot_loader #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned MAX_WORDS  = 8192,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter logic [7:0]  MAGIC      = 8'hF5
) (
  input  logic               clk,
  input  logic               reset,
  fifth_boot_loader_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHECK, S_RUN
  } state_t;

  state_t                state_q,     state_d;
  logic [15:0]           len_q,       len_d;
  logic [15:0]           idx_q,       idx_d;
  logic [7:0]            lo_q,        lo_d;
  logic [7:0]            chk_q,       chk_d;
  logic [TW-1:0]         tmo_q,       tmo_d;
  logic                  rx_ready_q,  rx_ready_d;
  logic                  wr_en_q,     wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q,   wr_addr_d;
  logic [15:0]           wr_data_q,   wr_data_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  done_q,      done_d;
  logic                  error_q,     error_d;

  logic                  accept;
  logic                  tmo_hit;
  logic [15:0]           len_rx;

  assign accept  = bus.rx_valid & rx_ready_q;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
  assign len_rx  = {bus.rx_data, len_q[7:0]};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    chk_d       = chk_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;

    if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.rx_data == MAGIC) begin
            state_d = S_LEN_LO;
            done_d  = 1'b0;
            error_d = 1'b0;
            chk_d   = '0;
            idx_d   = '0;
          end
        end
        S_LEN_LO: begin
          len_d[7:0] = bus.rx_data;
          chk_d      = chk_q ^ bus.rx_data;
          state_d    = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d[15:8] = bus.rx_data;
          chk_d       = chk_q ^ bus.rx_data;
          if (len_rx == '0 || 32'(len_rx) > MAX_WORDS) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          lo_d    = bus.rx_data;
          chk_d   = chk_q ^ bus.rx_data;
          state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          wr_en_d   = 1'b1;
          wr_data_d = {bus.rx_data, lo_q};
          wr_addr_d = ADDR_WIDTH'(idx_q);
          idx_d     = idx_q + 16'd1;
          chk_d     = chk_q ^ bus.rx_data;
          state_d   = (idx_q == len_q - 16'd1) ? S_CHECK : S_DATA_LO;
        end
        S_CHECK: begin
          if (bus.rx_data == chk_q) begin
            state_d     = S_RUN;
            cpu_reset_d = 1'b1;
            done_d      = 1'b1;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q == S_RUN) begin
      if (bus.load_req) begin
        state_d     = S_IDLE;
        cpu_reset_d = 1'b0;
        done_d      = 1'b0;
      end
    end else if (tmo_hit) begin
      // Idle timeout boots the resident image; mid-frame it aborts the load.
      if (state_q == S_IDLE) begin
        state_d     = S_RUN;
        cpu_reset_d = 1'b1;
      end else begin
        state_d = S_IDLE;
        error_d = 1'b1;
      end
    end

    if (state_q == S_RUN || accept || state_d != state_q) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    rx_ready_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      lo_q        <= '0;
      chk_q       <= '0;
      tmo_q       <= '0;
      rx_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      chk_q       <= chk_d;
      tmo_q       <= tmo_d;
      rx_ready_q  <= rx_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.rx_ready     = rx_ready_q;
  assign bus.code_wr_en   = wr_en_q;
  assign bus.code_wr_addr = wr_addr_q;
  assign bus.code_wr_data = wr_data_q;
  assign bus.cpu_reset    = cpu_reset_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_fifth_boot_loader.sv
// Bench for fifth_boot_loader: table frames, random frames against a frame-parsing
// model, and hand sequences for timeouts, reload and asynchronous reset.
module tb_fifth_boot_loader;

  localparam int unsigned AW   = 13;
  localparam int unsigned MAXW = 8;
  localparam int unsigned TMO  = 16;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  logic [AW+15:0] got_q[$];
  logic [AW+15:0] exp_q[$];

  fifth_boot_loader_if #(.ADDR_WIDTH(AW)) bus();

  fifth_boot_loader #(
    .ADDR_WIDTH(AW),
    .MAX_WORDS (MAXW),
    .TIMEOUT   (TMO),
    .MAGIC     (8'hF5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.code_wr_en) got_q.push_back({bus.code_wr_addr, bus.code_wr_data});
    if (bus.done && bus.error) begin
      miscompares++;
      $display("FAIL done_error_exclusive: got done=1 error=1, required not both");
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: parse the byte list as a whole frame and derive writes and outcome.
  function automatic void model(input logic [7:0] fr[$], output logic d, output logic e);
    int unsigned p;
    int unsigned len;
    logic [7:0]  x;
    exp_q.delete();
    d = 1'b0;
    e = 1'b0;
    p = 0;
    while (p < fr.size() && fr[p] != 8'hF5) p++;
    p++;
    len = {16'h0, fr[p+1], fr[p]};
    x   = fr[p] ^ fr[p+1];
    if (len == 0 || len > MAXW) begin
      e = 1'b1;
      return;
    end
    for (int unsigned i = 0; i < len; i++) begin
      exp_q.push_back({AW'(i), fr[p+3+2*i], fr[p+2+2*i]});
      x ^= fr[p+2+2*i] ^ fr[p+3+2*i];
    end
    if (fr[p+2+2*len] == x) d = 1'b1;
    else e = 1'b1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rx_ready) begin
      miscompares++;
      $display("FAIL rx_ready_wait: got rx_ready=0 for %0d cycles, required 1", n);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.load_req = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic finish_frame(input string name, input logic ed, input logic ee);
    repeat (2) @(negedge clk);
    check({name, " done"},      32'(bus.done),      32'(ed));
    check({name, " error"},     32'(bus.error),     32'(ee));
    check({name, " cpu_reset"}, 32'(bus.cpu_reset), 32'(ed));
    check({name, " rx_ready"},  32'(bus.rx_ready),  32'(!ed));
    check({name, " wr_count"},  32'(got_q.size()),  32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s wr%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic run_frame(input string name, input logic [7:0] fr[$],
                           input logic ed, input logic ee);
    logic md, me;
    do_reset();
    got_q.delete();
    model(fr, md, me);
    foreach (fr[i]) send_byte(fr[i]);
    finish_frame(name, ed, ee);
  endtask

  typedef struct {
    string        name;
    logic [159:0] b;   // frame bytes, last byte in the low 8 bits
    int unsigned  n;
    logic         ed;
    logic         ee;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [7:0] fr[$];
    logic       md, me;
    vectors     = 0;
    miscompares = 0;
    reset        = 1'b0;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.load_req = 1'b0;

    tbl[0] = '{"good2",   160'hF5_02_00_34_12_78_56_0A, 8, 1'b1, 1'b0};
    tbl[1] = '{"badchk",  160'hF5_02_00_34_12_78_56_0B, 8, 1'b0, 1'b1};
    tbl[2] = '{"garbage", 160'h00_AA_F5_00_00, 5, 1'b0, 1'b1};
    tbl[3] = '{"len9",    160'hF5_09_00, 3, 1'b0, 1'b1};
    tbl[4] = '{"lenmax",  160'hF5_08_00_01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10_18,
               20, 1'b1, 1'b0};
    tbl[5] = '{"len1",    160'hF5_01_00_FF_EE_10, 6, 1'b1, 1'b0};
    tbl[6] = '{"lenffff", 160'hF5_FF_FF, 3, 1'b0, 1'b1};

    // Reset values while held, then the idle timeout boots the core at edge TMO.
    repeat (2) @(negedge clk);
    check("rst rx_ready",  32'(bus.rx_ready),     0);
    check("rst wr_en",     32'(bus.code_wr_en),   0);
    check("rst wr_addr",   32'(bus.code_wr_addr), 0);
    check("rst wr_data",   32'(bus.code_wr_data), 0);
    check("rst cpu_reset", 32'(bus.cpu_reset),    0);
    check("rst done",      32'(bus.done),         0);
    check("rst error",     32'(bus.error),        0);
    reset = 1'b1;
    @(negedge clk);
    check("rel rx_ready", 32'(bus.rx_ready), 1);
    repeat (TMO - 2) @(negedge clk);
    check("idle_tmo before", 32'(bus.cpu_reset), 0);
    @(negedge clk);
    check("idle_tmo cpu_reset", 32'(bus.cpu_reset), 1);
    check("idle_tmo done",      32'(bus.done),      0);
    check("idle_tmo error",     32'(bus.error),     0);
    check("idle_tmo rx_ready",  32'(bus.rx_ready),  0);

    for (int k = 0; k < 7; k++) begin
      fr = {};
      for (int unsigned i = 0; i < tbl[k].n; i++)
        fr.push_back(tbl[k].b[8*(tbl[k].n-1-i) +: 8]);
      run_frame(tbl[k].name, fr, tbl[k].ed, tbl[k].ee);
    end

    // Timeout mid-frame.
    do_reset();
    got_q.delete();
    send_byte(8'hF5);
    send_byte(8'h02);
    repeat (20) @(negedge clk);
    check("frame_tmo error",     32'(bus.error),     1);
    check("frame_tmo rx_ready",  32'(bus.rx_ready),  1);
    check("frame_tmo cpu_reset", 32'(bus.cpu_reset), 0);
    check("frame_tmo writes",    32'(got_q.size()),  0);

    // load_req ignored during a frame, honoured in RUN even with rx_valid high.
    do_reset();
    got_q.delete();
    fr = {8'hF5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
    model(fr, md, me);
    send_byte(8'hF5);
    bus.load_req = 1'b1;
    send_byte(8'h02);
    bus.load_req = 1'b0;
    for (int i = 2; i < 8; i++) send_byte(fr[i]);
    finish_frame("ldreq_ignored", 1'b1, 1'b0);
    bus.load_req = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hF5;
    @(negedge clk);
    bus.load_req = 1'b0;
    bus.rx_valid = 1'b0;
    check("reload cpu_reset", 32'(bus.cpu_reset), 0);
    check("reload rx_ready",  32'(bus.rx_ready),  1);
    check("reload done",      32'(bus.done),      0);
    got_q.delete();
    foreach (fr[i]) send_byte(fr[i]);
    finish_frame("reload", 1'b1, 1'b0);

    // Asynchronous reset while DATA_HI byte is offered.
    do_reset();
    got_q.delete();
    for (int i = 0; i < 5; i++) send_byte(fr[i]);
    send_byte(8'h78);
    bus.rx_data  = 8'h56;
    bus.rx_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("areset wr_data",   32'(bus.code_wr_data), 0);
    check("areset wr_addr",   32'(bus.code_wr_addr), 0);
    check("areset wr_en",     32'(bus.code_wr_en),   0);
    check("areset rx_ready",  32'(bus.rx_ready),     0);
    check("areset cpu_reset", 32'(bus.cpu_reset),    0);
    check("areset done",      32'(bus.done),         0);
    check("areset error",     32'(bus.error),        0);
    bus.rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    got_q.delete();
    model(fr, md, me);
    foreach (fr[i]) send_byte(fr[i]);
    finish_frame("after_areset", 1'b1, 1'b0);

    for (int t = 0; t < 24; t++) begin
      int unsigned len;
      logic [7:0]  x, b;
      fr = {};
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hF5) b = 8'h00;
        fr.push_back(b);
      end
      len = $urandom_range(0, 9);
      fr.push_back(8'hF5);
      fr.push_back(len[7:0]);
      fr.push_back(len[15:8]);
      x = len[7:0] ^ len[15:8];
      if (len >= 1 && len <= MAXW) begin
        for (int unsigned i = 0; i < 2 * len; i++) begin
          b = 8'($urandom_range(0, 255));
          fr.push_back(b);
          x ^= b;
        end
        if ($urandom_range(0, 2) == 0) x ^= 8'($urandom_range(1, 255));
        fr.push_back(x);
      end
      model(fr, md, me);
      run_frame($sformatf("rnd%0d", t), fr, md, me);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
